// File: rtl/hero_bus_arbiter.sv
// Round-robin arbiter sharing one hero write bus among N_REQ requesters.
// A grant is held for a whole transaction and force-released after MAX_BEATS accepted beats.
`timescale 1ns/1ps
module hero_bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int HERO_WIDTH = 36,
  parameter int SUB_W      = 8,
  parameter int MAX_BEATS  = 16,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [2*N_REQ-1:0]          req_ct_i,
  input  logic [HERO_WIDTH*N_REQ-1:0] req_wdat_i,
  input  logic [SUB_W*N_REQ-1:0]      req_sub_i,
  input  logic [N_REQ-1:0]            req_clk_en_i,
  output logic [N_REQ-1:0]            req_rdy_o,
  output logic [1:0]                  hero_ct_o,
  output logic [HERO_WIDTH-1:0]       hero_wdat_o,
  output logic [SUB_W-1:0]            hero_sub_o,
  output logic                        hero_clk_en_o,
  input  logic                        hero_rdy_i,
  output logic                        hero_gnt_vld_o,
  output logic [ID_W-1:0]             hero_gnt_id_o,
  output logic                        err_overlong_o
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [1:0] CT_IDLE  = 2'd0;
  localparam logic [1:0] CT_VALID = 2'd1;
  localparam logic [1:0] CT_DONE  = 2'd2;
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

  typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic              gnt_vld_q, gnt_vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [N_REQ-1:0]      requesting_s;
  logic [ID_W-1:0]       scan_idx_s [N_REQ];
  logic                  win_found_s;
  logic [ID_W-1:0]       win_id_s;
  logic [1:0]            sel_ct_s;
  logic [HERO_WIDTH-1:0] sel_wdat_s;
  logic [SUB_W-1:0]      sel_sub_s;
  logic                  sel_clk_en_s;
  logic                  accept_s;

  // Code 3 is illegal and behaves exactly like IDLE everywhere.
  function automatic logic is_active(input logic [1:0] ct);
    return (ct == CT_VALID) || (ct == CT_DONE);
  endfunction

  // Per-requester request decode and rotated scan order starting after last winner.
  always_comb begin
    requesting_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      requesting_s[i] = is_active(req_ct_i[2*i +: 2]);
      scan_idx_s[i]   = ID_W'((int'(last_q) + i + 1) % N_REQ);
    end
  end

  // Walk the scan order from lowest priority to highest so the first hit wins.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      win_found_s = win_found_s | requesting_s[scan_idx_s[k]];
      win_id_s    = requesting_s[scan_idx_s[k]] ? scan_idx_s[k] : win_id_s;
    end
  end

  // Field mux selected by the registered grant.
  always_comb begin
    sel_ct_s     = CT_IDLE;
    sel_wdat_s   = '0;
    sel_sub_s    = '0;
    sel_clk_en_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_ct_s     = (gnt_id_q == ID_W'(i)) ? req_ct_i[2*i +: 2] : sel_ct_s;
      sel_wdat_s   = (gnt_id_q == ID_W'(i)) ? req_wdat_i[HERO_WIDTH*i +: HERO_WIDTH] : sel_wdat_s;
      sel_sub_s    = (gnt_id_q == ID_W'(i)) ? req_sub_i[SUB_W*i +: SUB_W] : sel_sub_s;
      sel_clk_en_s = (gnt_id_q == ID_W'(i)) ? req_clk_en_i[i] : sel_clk_en_s;
    end
  end

  // Bus outputs and per-requester ready, all quiet unless a grant is held.
  always_comb begin
    hero_ct_o     = CT_IDLE;
    hero_wdat_o   = '0;
    hero_sub_o    = '0;
    hero_clk_en_o = 1'b0;
    req_rdy_o     = '0;
    if (gnt_vld_q) begin
      hero_ct_o     = is_active(sel_ct_s) ? sel_ct_s : CT_IDLE;
      hero_wdat_o   = sel_wdat_s;
      hero_sub_o    = sel_sub_s;
      hero_clk_en_o = sel_clk_en_s;
      for (int i = 0; i < N_REQ; i++) begin
        req_rdy_o[i] = (gnt_id_q == ID_W'(i)) & hero_rdy_i;
      end
    end else begin
      hero_ct_o     = CT_IDLE;
      req_rdy_o     = '0;
    end
  end

  assign accept_s       = gnt_vld_q && is_active(sel_ct_s) && hero_rdy_i;
  assign hero_gnt_vld_o = gnt_vld_q;
  assign hero_gnt_id_o  = gnt_id_q;
  assign err_overlong_o = err_q;

  // Next-state logic: arbitrate in ARB, count beats and release in LOCK.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_id_d  = gnt_id_q;
    gnt_vld_d = gnt_vld_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (win_found_s) begin
          state_d   = ST_LOCK;
          gnt_id_d  = win_id_s;
          gnt_vld_d = 1'b1;
          cnt_d     = '0;
        end else begin
          gnt_vld_d = 1'b0;
        end
      end
      ST_LOCK: begin
        // DONE on the last allowed beat is a clean release, not an overlong error.
        if (accept_s && ((sel_ct_s == CT_DONE) || (cnt_q == CNT_LAST))) begin
          state_d   = ST_ARB;
          gnt_vld_d = 1'b0;
          last_d    = gnt_id_q;
          cnt_d     = '0;
          err_d     = (sel_ct_s != CT_DONE);
        end else if (accept_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d   = ST_ARB;
        gnt_vld_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ARB;
      last_q    <= LAST_RST;
      gnt_id_q  <= '0;
      gnt_vld_q <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_id_q  <= gnt_id_d;
      gnt_vld_q <= gnt_vld_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_hero_bus_arbiter.sv
// Scoreboard bench for hero_bus_arbiter: per-requester beat queues drive the inputs,
// expected bus beats are queued at load time and popped on each accepted beat.
`timescale 1ns/1ps
module tb_hero_bus_arbiter;
  localparam int N  = 4;
  localparam int W  = 36;
  localparam int S  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [2*N-1:0] req_ct;
  logic [W*N-1:0] req_wdat;
  logic [S*N-1:0] req_sub;
  logic [N-1:0]   req_clk_en;
  logic [N-1:0]   req_rdy_o;
  logic [1:0]     hero_ct_o;
  logic [W-1:0]   hero_wdat_o;
  logic [S-1:0]   hero_sub_o;
  logic           hero_clk_en_o;
  logic           hero_rdy;
  logic           hero_gnt_vld_o;
  logic [IW-1:0]  hero_gnt_id_o;
  logic           err_overlong_o;

  always #5 clk = ~clk;

  hero_bus_arbiter #(.N_REQ(N), .HERO_WIDTH(W), .SUB_W(S), .MAX_BEATS(16)) dut (
    .clk(clk), .rst(rst),
    .req_ct_i(req_ct), .req_wdat_i(req_wdat), .req_sub_i(req_sub), .req_clk_en_i(req_clk_en),
    .req_rdy_o(req_rdy_o),
    .hero_ct_o(hero_ct_o), .hero_wdat_o(hero_wdat_o), .hero_sub_o(hero_sub_o),
    .hero_clk_en_o(hero_clk_en_o), .hero_rdy_i(hero_rdy),
    .hero_gnt_vld_o(hero_gnt_vld_o), .hero_gnt_id_o(hero_gnt_id_o),
    .err_overlong_o(err_overlong_o)
  );

  typedef struct packed { logic [1:0] ct; logic [W-1:0] wdat; } beat_t;
  typedef struct packed { logic [1:0] id; logic [1:0] ct; logic [W-1:0] wdat; } exp_t;

  beat_t stim_q [N][$];
  exp_t  exp_q [$];
  logic  consume [N];
  int    rdy_cnt [N];
  int    err_cnt;
  int    n_chk  = 0;
  int    n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [S-1:0] sub_of(input int id, input logic [W-1:0] wd);
    return {wd[5:0], 2'(id)};
  endfunction

  function automatic bit all_idle();
    bit r = (exp_q.size() == 0) && !hero_gnt_vld_o;
    for (int i = 0; i < N; i++) r = r && (stim_q[i].size() == 0);
    return r;
  endfunction

  task automatic push_stim(input int id, input logic [1:0] ct, input logic [W-1:0] wd);
    beat_t b;
    b.ct = ct; b.wdat = wd;
    stim_q[id].push_back(b);
  endtask

  task automatic push_exp(input int id, input logic [1:0] ct, input logic [W-1:0] wd);
    exp_t e;
    e.id = 2'(id); e.ct = ct; e.wdat = wd;
    exp_q.push_back(e);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
    err_cnt = 0;
  endtask

  task automatic wait_gnt(input string tag);
    int c = 0;
    @(negedge clk);
    while (!hero_gnt_vld_o && c < 50) begin
      @(negedge clk);
      c++;
    end
    check_eq(tag, hero_gnt_vld_o, 1);
  endtask

  task automatic wait_done(input string tag, output int cyc);
    int c = 0;
    @(negedge clk);
    while (!all_idle() && c < 200) begin
      @(negedge clk);
      c++;
    end
    cyc = c;
    check_eq(tag, all_idle(), 1);
  endtask

  // Requester driver: pop the front beat once it was consumed, then present the next one.
  initial begin
    req_ct = '0; req_wdat = '0; req_sub = '0; req_clk_en = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (consume[i] && stim_q[i].size() > 0) void'(stim_q[i].pop_front());
        if (stim_q[i].size() > 0) begin
          req_ct[2*i +: 2]   = stim_q[i][0].ct;
          req_wdat[W*i +: W] = stim_q[i][0].wdat;
          req_sub[S*i +: S]  = sub_of(i, stim_q[i][0].wdat);
          req_clk_en[i]      = 1'b1;
        end else begin
          req_ct[2*i +: 2]   = 2'd0;
          req_wdat[W*i +: W] = '0;
          req_sub[S*i +: S]  = '0;
          req_clk_en[i]      = 1'b0;
        end
      end
    end
  end

  // Monitor: consumption flags, counters and scoreboard compare on every accepted beat.
  initial begin
    exp_t e;
    int   pending;
    for (int i = 0; i < N; i++) consume[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (stim_q[i].size() > 0) begin
          if (stim_q[i][0].ct == 2'd1 || stim_q[i][0].ct == 2'd2)
            consume[i] = req_rdy_o[i];
          else
            consume[i] = hero_gnt_vld_o && (int'(hero_gnt_id_o) == i);
        end else begin
          consume[i] = 1'b0;
        end
        if (req_rdy_o[i] && hero_ct_o != 2'd0) rdy_cnt[i]++;
      end
      if (err_overlong_o) err_cnt++;
      if (hero_ct_o != 2'd0 && hero_rdy) begin
        pending = exp_q.size();
        check_eq("sb_pending", pending != 0, 1);
        if (pending != 0) begin
          e = exp_q.pop_front();
          check_eq("sb_id", hero_gnt_id_o, e.id);
          check_eq("sb_ct", hero_ct_o, e.ct);
          check_eq("sb_wdat", hero_wdat_o, e.wdat);
          check_eq("sb_sub", hero_sub_o, sub_of(int'(e.id), e.wdat));
          check_eq("sb_clk_en", hero_clk_en_o, 1);
          check_eq("sb_req_rdy", req_rdy_o, 4'b0001 << e.id);
        end
      end
    end
  end

  initial begin
    int cyc;
    rst = 1'b1;
    hero_rdy = 1'b1;
    clear_counts();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_gnt_vld", hero_gnt_vld_o, 0);
    check_eq("rst_gnt_id", hero_gnt_id_o, 0);
    check_eq("rst_err", err_overlong_o, 0);
    check_eq("rst_ct", hero_ct_o, 0);
    check_eq("rst_req_rdy", req_rdy_o, 0);
    rst = 1'b0;

    // Two competing 3-beat transactions: id0 first, then id2, one bubble each.
    @(posedge clk); #1;
    clear_counts();
    for (int k = 0; k < 3; k++) begin
      push_stim(0, (k == 2) ? 2'd2 : 2'd1, 36'h1_0000_00A0 + 36'(k));
      push_stim(2, (k == 2) ? 2'd2 : 2'd1, 36'h2_0000_00B0 + 36'(k));
    end
    for (int k = 0; k < 3; k++) push_exp(0, (k == 2) ? 2'd2 : 2'd1, 36'h1_0000_00A0 + 36'(k));
    for (int k = 0; k < 3; k++) push_exp(2, (k == 2) ? 2'd2 : 2'd1, 36'h2_0000_00B0 + 36'(k));
    wait_done("t1_done", cyc);
    check_eq("t1_cycles", cyc, 8);
    check_eq("t1_rdy0", rdy_cnt[0], 3);
    check_eq("t1_rdy2", rdy_cnt[2], 3);

    // Backpressure: the first beat is stalled for 4 granted cycles.
    @(posedge clk); #1;
    clear_counts();
    hero_rdy = 1'b0;
    push_stim(1, 2'd1, 36'h9_ABCD_1234); push_exp(1, 2'd1, 36'h9_ABCD_1234);
    push_stim(1, 2'd2, 36'h9_ABCD_5678); push_exp(1, 2'd2, 36'h9_ABCD_5678);
    wait_gnt("t2_gnt");
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check_eq("t2_hold_wdat", hero_wdat_o, 36'h9_ABCD_1234);
      check_eq("t2_stall_rdy", req_rdy_o, 0);
    end
    @(posedge clk); #1;
    hero_rdy = 1'b1;
    @(negedge clk);
    check_eq("t2_hold_wdat5", hero_wdat_o, 36'h9_ABCD_1234);
    check_eq("t2_rdy1", req_rdy_o, 4'b0010);
    wait_done("t2_done", cyc);
    check_eq("t2_beats", rdy_cnt[1], 2);

    // Single-beat DONE from id3.
    @(posedge clk); #1;
    clear_counts();
    push_stim(3, 2'd2, 36'h3_3333_0001); push_exp(3, 2'd2, 36'h3_3333_0001);
    @(negedge clk);
    check_eq("t3_arb_bubble", hero_gnt_vld_o, 0);
    @(negedge clk);
    check_eq("t3_gnt_vld", hero_gnt_vld_o, 1);
    check_eq("t3_gnt_id", hero_gnt_id_o, 3);
    @(negedge clk);
    check_eq("t3_released", hero_gnt_vld_o, 0);
    wait_done("t3_done", cyc);
    check_eq("t3_beats", rdy_cnt[3], 1);

    // Overlong: 17 VALID beats then DONE from id0 while id1 waits.
    @(posedge clk); #1;
    clear_counts();
    for (int k = 0; k < 17; k++) push_stim(0, 2'd1, 36'h4_0000_0000 + 36'(k));
    push_stim(0, 2'd2, 36'h4_0000_0011);
    push_stim(1, 2'd2, 36'h4_1111_0000);
    for (int k = 0; k < 16; k++) push_exp(0, 2'd1, 36'h4_0000_0000 + 36'(k));
    push_exp(1, 2'd2, 36'h4_1111_0000);
    push_exp(0, 2'd1, 36'h4_0000_0010);
    push_exp(0, 2'd2, 36'h4_0000_0011);
    cyc = 0;
    @(negedge clk);
    while (!err_overlong_o && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t4_err_seen", err_overlong_o, 1);
    check_eq("t4_err_at_16", rdy_cnt[0], 16);
    check_eq("t4_err_release", hero_gnt_vld_o, 0);
    @(negedge clk);
    check_eq("t4_next_vld", hero_gnt_vld_o, 1);
    check_eq("t4_next_id", hero_gnt_id_o, 1);
    check_eq("t4_err_pulse", err_overlong_o, 0);
    wait_done("t4_done", cyc);
    check_eq("t4_err_cnt", err_cnt, 1);
    check_eq("t4_beats0", rdy_cnt[0], 18);

    // Gaps (IDLE, illegal 3, IDLE) keep id2 locked while id1 requests.
    @(posedge clk); #1;
    clear_counts();
    push_stim(2, 2'd1, 36'h5_0000_0001); push_exp(2, 2'd1, 36'h5_0000_0001);
    push_stim(2, 2'd0, 36'h0);
    push_stim(2, 2'd3, 36'h5_0000_0003);
    push_stim(2, 2'd0, 36'h0);
    push_stim(2, 2'd2, 36'h5_0000_0005); push_exp(2, 2'd2, 36'h5_0000_0005);
    wait_gnt("t5_gnt");
    check_eq("t5_gnt_id", hero_gnt_id_o, 2);
    push_stim(1, 2'd2, 36'h5_1111_0000); push_exp(1, 2'd2, 36'h5_1111_0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("t5_gap_vld", hero_gnt_vld_o, 1);
      check_eq("t5_gap_id", hero_gnt_id_o, 2);
      check_eq("t5_gap_ct", hero_ct_o, 0);
      check_eq("t5_gap_rdy1", req_rdy_o[1], 0);
    end
    wait_done("t5_done", cyc);
    check_eq("t5_beats1", rdy_cnt[1], 1);

    // Reset during beat 2 of id1, then id0/id1/id2 contend after release.
    @(posedge clk); #1;
    clear_counts();
    for (int k = 0; k < 3; k++) push_stim(1, (k == 2) ? 2'd2 : 2'd1, 36'h6_0000_0000 + 36'(k));
    for (int k = 0; k < 3; k++) push_exp(1, (k == 2) ? 2'd2 : 2'd1, 36'h6_0000_0000 + 36'(k));
    wait_gnt("t6_gnt");
    check_eq("t6_gnt_id", hero_gnt_id_o, 1);
    @(negedge clk);
    check_eq("t6_beat2", hero_wdat_o, 36'h6_0000_0001);
    #1 rst = 1'b1;
    #1;
    check_eq("t6_rst_vld", hero_gnt_vld_o, 0);
    check_eq("t6_rst_id", hero_gnt_id_o, 0);
    check_eq("t6_rst_ct", hero_ct_o, 0);
    check_eq("t6_rst_wdat", hero_wdat_o, 0);
    check_eq("t6_rst_rdy", req_rdy_o, 0);
    check_eq("t6_rst_err", err_overlong_o, 0);
    @(posedge clk); #3;
    for (int i = 0; i < N; i++) stim_q[i].delete();
    exp_q.delete();
    push_stim(0, 2'd2, 36'h7_0000_0000);
    push_stim(1, 2'd2, 36'h7_1111_0000);
    push_stim(2, 2'd2, 36'h7_2222_0000);
    push_exp(0, 2'd2, 36'h7_0000_0000);
    push_exp(1, 2'd2, 36'h7_1111_0000);
    push_exp(2, 2'd2, 36'h7_2222_0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_gnt("t6_regnt");
    check_eq("t6_first_id", hero_gnt_id_o, 0);
    wait_done("t6_done", cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
